// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter.
//   state_t    : arbiter FSM encoding (LOAD / DRAIN / RUN), 2 bits
//   HALT_OP    : word returned for out-of-range instruction reads
//   ADDR_W_DEF : default instruction-memory word-address width
package imem_pkg;

  localparam int unsigned ADDR_W_DEF = 14;
  localparam logic [31:0] HALT_OP    = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit saturating up-counter.
//   clk : clock
//   clr : synchronous clear (takes priority over inc)
//   inc : add one, holding at 16'hFFFF
//   cnt : current count
module sat_cnt16 (
  input  logic        clk,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/imem_arb.sv
// Instruction-memory arbiter: shares one single-port synchronous RAM between
// the CPU fetch stage and the image loader. After reset (BOOT_LOAD=1) the CPU
// is held in reset while the loader writes the image; ld_done moves through a
// one-cycle DRAIN into RUN, where fetch owns the RAM. A halted CPU lets the
// loader take the RAM back.
//   clk, rst                    : clock, synchronous active-high reset
//   fetch_req/addr              : fetch read request, byte address
//   fetch_gnt/valid/data/stall  : grant, 1-cycle-later data, stall
//   ld_req/addr/wdata, ld_gnt   : loader write request and grant
//   ld_done                     : end-of-image pulse
//   cpu_halted, cpu_rst         : CPU halted status, CPU reset hold
//   mem_en/we/addr/wdata/rdata  : RAM port (read latency 1)
//   ld_count                    : writes performed since entering LOAD
//   misalign                    : sticky flag for misaligned granted access
module imem_arb
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter bit          BOOT_LOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [31:0]       fetch_data,
  output logic              fetch_stall,
  input  logic              ld_req,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_gnt,
  input  logic              ld_done,
  input  logic              cpu_halted,
  output logic              cpu_rst,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       ld_count,
  output logic              misalign
);

  localparam state_t BOOT_STATE = BOOT_LOAD ? ST_LOAD : ST_RUN;

  state_t state, state_nx;
  logic   fetch_in_range, ld_in_range;
  logic   rd_pend, rd_oob;
  logic   mis_set, ld_wr, cnt_clr;

  // Any address bit above the RAM's word range makes the access out of range.
  assign fetch_in_range = (fetch_addr >> (ADDR_W + 2)) == 32'd0;
  assign ld_in_range    = (ld_addr    >> (ADDR_W + 2)) == 32'd0;

  always_comb begin
    state_nx  = state;
    cpu_rst   = 1'b1;
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mis_set   = 1'b0;
    ld_wr     = 1'b0;
    // rst suppresses every grant and RAM access in the reset cycle itself.
    if (!rst) begin
      unique case (state)
        ST_LOAD: begin
          ld_gnt = ld_req;
          if (ld_req) begin
            mis_set = |ld_addr[1:0];
            if (ld_in_range) begin
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = ld_addr[ADDR_W+1:2];
              mem_wdata = ld_wdata;
              ld_wr     = 1'b1;
            end
          end
          if (ld_done) state_nx = ST_DRAIN;
        end
        ST_DRAIN: begin
          state_nx = ST_RUN;
        end
        ST_RUN: begin
          cpu_rst = 1'b0;
          if (fetch_req) begin
            fetch_gnt = 1'b1;
            mis_set   = |fetch_addr[1:0];
            mem_en    = fetch_in_range;
            mem_addr  = fetch_addr[ADDR_W+1:2];
          end else if (ld_req && cpu_halted) begin
            // Switch only; the write itself is granted in the first LOAD cycle.
            state_nx = ST_LOAD;
          end
        end
        default: state_nx = BOOT_STATE;
      endcase
    end
  end

  assign fetch_stall = fetch_req & ~fetch_gnt;
  assign cnt_clr     = rst | ((state == ST_RUN) && (state_nx == ST_LOAD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT_STATE;
      rd_pend  <= 1'b0;
      rd_oob   <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_pend  <= fetch_gnt;
      rd_oob   <= fetch_gnt & ~fetch_in_range;
      misalign <= misalign | mis_set;
    end
  end

  // Read pipeline is independent of state so a read granted just before a
  // RUN->LOAD switch is still delivered.
  assign fetch_valid = rd_pend;
  assign fetch_data  = rd_pend ? (rd_oob ? HALT_OP : mem_rdata) : '0;

  sat_cnt16 u_cnt (
    .clk (clk),
    .clr (cnt_clr),
    .inc (ld_wr),
    .cnt (ld_count)
  );

endmodule

// File: tb/tb_imem_arb.sv
module tb_imem_arb;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt, fetch_valid, fetch_stall;
  logic [31:0] fetch_data;
  logic        ld_req;
  logic [31:0] ld_addr, ld_wdata;
  logic        ld_gnt, ld_done, cpu_halted, cpu_rst;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [15:0] ld_count;
  logic        misalign;

  // second instance booting straight into RUN
  logic        r_fetch_gnt, r_fetch_valid, r_fetch_stall, r_ld_gnt, r_cpu_rst;
  logic [31:0] r_fetch_data, r_mem_wdata;
  logic        r_mem_en, r_mem_we, r_misalign;
  logic [13:0] r_mem_addr;
  logic [15:0] r_ld_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned wr_cnt  = 0;

  logic [31:0] ram [0:16383];

  imem_arb #(.ADDR_W(14), .BOOT_LOAD(1'b1)) u_dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .fetch_stall(fetch_stall), .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_done(ld_done),
    .cpu_halted(cpu_halted), .cpu_rst(cpu_rst), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ld_count(ld_count), .misalign(misalign)
  );

  imem_arb #(.ADDR_W(14), .BOOT_LOAD(1'b0)) u_run (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(r_fetch_gnt), .fetch_valid(r_fetch_valid), .fetch_data(r_fetch_data),
    .fetch_stall(r_fetch_stall), .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(r_ld_gnt), .ld_done(ld_done),
    .cpu_halted(cpu_halted), .cpu_rst(r_cpu_rst), .mem_en(r_mem_en), .mem_we(r_mem_we),
    .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .mem_rdata(32'h0),
    .ld_count(r_ld_count), .misalign(r_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-port synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rst, fr;
    logic [31:0] fa;
    logic        ch, lr;
    logic [31:0] la, lw;
    logic        ldn;
    logic        cr, fg, st, lg, en, we;
    logic [13:0] ad;
    logic [31:0] wd;
    logic        chk_reg, fv;
    logic [31:0] fd;
    logic        chk_fd;
    logic [15:0] cnt;
    logic        mis;
  } vec_t;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;
  localparam logic [31:0] A0 = 32'h1111_0000, A1 = 32'h2222_1111,
                          A2 = 32'h3333_2222, A3 = 32'h4444_3333;
  localparam logic [31:0] Z = 32'h0;

  vec_t vecs [11];

  initial begin
    int unsigned wr0;
    rst = 1'b0; fetch_req = 1'b0; fetch_addr = '0; cpu_halted = 1'b0;
    ld_req = 1'b0; ld_addr = '0; ld_wdata = '0; ld_done = 1'b0;

    //           rst fr fa             ch lr la      lw  ldn | cr fg st lg en we ad     wd  | chk fv fd  chkfd cnt     mis
    vecs[0]  = '{I, O, Z,             O, O, Z,      Z,  O,   I, O, O, O, O, O, 14'd0, Z,   O, O, Z,  O, 16'd0, O};
    vecs[1]  = '{O, O, Z,             O, I, Z,      A0, O,   I, O, O, I, I, I, 14'd0, A0,  I, O, Z,  I, 16'd0, O};
    vecs[2]  = '{O, O, Z,             O, I, 32'h4,  A1, O,   I, O, O, I, I, I, 14'd1, A1,  I, O, Z,  O, 16'd1, O};
    vecs[3]  = '{O, O, Z,             O, I, 32'h8,  A2, O,   I, O, O, I, I, I, 14'd2, A2,  I, O, Z,  O, 16'd2, O};
    vecs[4]  = '{O, I, Z,             O, I, 32'hC,  A3, I,   I, O, I, I, I, I, 14'd3, A3,  I, O, Z,  O, 16'd3, O};
    vecs[5]  = '{O, O, Z,             O, O, Z,      Z,  O,   I, O, O, O, O, O, 14'd0, Z,   I, O, Z,  O, 16'd4, O};
    vecs[6]  = '{O, I, 32'h8,         O, O, Z,      Z,  O,   O, I, O, O, I, O, 14'd2, Z,   I, O, Z,  O, 16'd4, O};
    vecs[7]  = '{O, O, Z,             O, O, Z,      Z,  O,   O, O, O, O, O, O, 14'd0, Z,   I, I, A2, I, 16'd4, O};
    vecs[8]  = '{O, I, 32'h0010_0000, O, O, Z,      Z,  O,   O, I, O, O, O, O, 14'd0, Z,   I, O, Z,  O, 16'd4, O};
    vecs[9]  = '{O, I, 32'h6,         O, O, Z,      Z,  O,   O, I, O, O, I, O, 14'd1, Z,   I, I, Z,  I, 16'd4, O};
    vecs[10] = '{O, O, Z,             O, O, Z,      Z,  O,   O, O, O, O, O, O, 14'd0, Z,   I, I, A1, I, 16'd4, I};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst; fetch_req = vecs[i].fr; fetch_addr = vecs[i].fa;
      cpu_halted = vecs[i].ch; ld_req = vecs[i].lr; ld_addr = vecs[i].la;
      ld_wdata = vecs[i].lw; ld_done = vecs[i].ldn;
      #1;
      chk($sformatf("row%0d_cpu_rst", i), {31'd0, cpu_rst}, {31'd0, vecs[i].cr});
      chk($sformatf("row%0d_fetch_gnt", i), {31'd0, fetch_gnt}, {31'd0, vecs[i].fg});
      chk($sformatf("row%0d_fetch_stall", i), {31'd0, fetch_stall}, {31'd0, vecs[i].st});
      chk($sformatf("row%0d_ld_gnt", i), {31'd0, ld_gnt}, {31'd0, vecs[i].lg});
      chk($sformatf("row%0d_mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].en});
      chk($sformatf("row%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].we});
      if (vecs[i].en) chk($sformatf("row%0d_mem_addr", i), {18'd0, mem_addr}, {18'd0, vecs[i].ad});
      if (vecs[i].we) chk($sformatf("row%0d_mem_wdata", i), mem_wdata, vecs[i].wd);
      if (vecs[i].chk_reg) begin
        chk($sformatf("row%0d_fetch_valid", i), {31'd0, fetch_valid}, {31'd0, vecs[i].fv});
        chk($sformatf("row%0d_ld_count", i), {16'd0, ld_count}, {16'd0, vecs[i].cnt});
        chk($sformatf("row%0d_misalign", i), {31'd0, misalign}, {31'd0, vecs[i].mis});
      end
      if (vecs[i].chk_fd) chk($sformatf("row%0d_fetch_data", i), fetch_data, vecs[i].fd);
      if (i == 0) chk("run_inst_cpu_rst_in_rst", {31'd0, r_cpu_rst}, 32'd1);
      if (i == 1) chk("run_inst_cpu_rst_after_rst", {31'd0, r_cpu_rst}, 32'd0);
      if (i == 4) chk("run_inst_fetch_gnt", {31'd0, r_fetch_gnt}, 32'd1);
      @(negedge clk);
    end

    // RUN with a running CPU: loader is locked out, fetch keeps working
    wr0 = wr_cnt;
    for (int k = 0; k < 10; k++) begin
      cpu_halted = 1'b0; ld_req = 1'b1; ld_addr = 32'h0; ld_wdata = 32'hDEAD_BEEF;
      fetch_req = (k % 2 == 0); fetch_addr = 32'hC;
      #1;
      chk($sformatf("lockout%0d_ld_gnt", k), {31'd0, ld_gnt}, 32'd0);
      chk($sformatf("lockout%0d_mem_we", k), {31'd0, mem_we}, 32'd0);
      if (k % 2 == 0) begin
        chk($sformatf("lockout%0d_fetch_gnt", k), {31'd0, fetch_gnt}, 32'd1);
        chk($sformatf("lockout%0d_mem_addr", k), {18'd0, mem_addr}, 32'd3);
      end else begin
        chk($sformatf("lockout%0d_fetch_valid", k), {31'd0, fetch_valid}, 32'd1);
        chk($sformatf("lockout%0d_fetch_data", k), fetch_data, A3);
      end
      @(negedge clk);
    end
    chk("lockout_no_write", wr_cnt - wr0, 32'd0);
    chk("lockout_ram0", ram[0], A0);

    // halted CPU: fetch still wins the cycle it requests
    cpu_halted = 1'b1; ld_req = 1'b1; ld_addr = 32'h10; ld_wdata = 32'h5555_AAAA;
    fetch_req = 1'b1; fetch_addr = 32'h4;
    #1;
    chk("halt_fetch_prio_gnt", {31'd0, fetch_gnt}, 32'd1);
    chk("halt_fetch_prio_ld_gnt", {31'd0, ld_gnt}, 32'd0);
    @(negedge clk);
    // switch cycle: not yet granted, pending read still delivered
    fetch_req = 1'b0;
    #1;
    chk("switch_ld_gnt", {31'd0, ld_gnt}, 32'd0);
    chk("switch_mem_en", {31'd0, mem_en}, 32'd0);
    chk("switch_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    chk("switch_fetch_valid", {31'd0, fetch_valid}, 32'd1);
    chk("switch_fetch_data", fetch_data, A1);
    @(negedge clk);
    #1;
    chk("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("reload_ld_count_clr", {16'd0, ld_count}, 32'd0);
    chk("reload_ld_gnt", {31'd0, ld_gnt}, 32'd1);
    chk("reload_mem_we", {31'd0, mem_we}, 32'd1);
    chk("reload_mem_addr", {18'd0, mem_addr}, 32'd4);
    chk("reload_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    @(negedge clk);
    // out-of-range loader write: granted, dropped
    ld_addr = 32'h0010_0000;
    #1;
    chk("ld_oob_gnt", {31'd0, ld_gnt}, 32'd1);
    chk("ld_oob_mem_en", {31'd0, mem_en}, 32'd0);
    chk("ld_oob_count_before", {16'd0, ld_count}, 32'd1);
    @(negedge clk);
    ld_addr = 32'h14; ld_wdata = 32'h6666_0000;
    #1;
    chk("ld_oob_count_after", {16'd0, ld_count}, 32'd1);
    @(negedge clk);
    // rst in the middle of the burst
    wr0 = wr_cnt;
    rst = 1'b1; ld_addr = 32'h18; ld_wdata = 32'h7777_0000;
    #1;
    chk("midrst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("midrst_ld_gnt", {31'd0, ld_gnt}, 32'd0);
    chk("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    @(negedge clk);
    rst = 1'b0; ld_req = 1'b0;
    #1;
    chk("midrst_no_write", wr_cnt - wr0, 32'd0);
    chk("midrst_ld_count", {16'd0, ld_count}, 32'd0);
    chk("midrst_misalign", {31'd0, misalign}, 32'd0);
    chk("midrst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("midrst_load_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    ld_req = 1'b1; ld_addr = 32'h20; ld_wdata = 32'h8888_0000;
    #1;
    chk("midrst_load_gnt", {31'd0, ld_gnt}, 32'd1);
    @(negedge clk);

    // saturation: 65536 performed writes leave the count at FFFF
    for (int k = 1; k < 65536; k++) @(negedge clk);
    #1;
    chk("sat_before_last", {16'd0, ld_count}, 32'h0000_FFFF);
    @(negedge clk);
    #1;
    chk("sat_hold", {16'd0, ld_count}, 32'h0000_FFFF);
    ld_done = 1'b1;
    @(negedge clk);
    ld_req = 1'b0; ld_done = 1'b0;
    #1;
    chk("sat_drain_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    @(negedge clk);
    #1;
    chk("sat_run_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, instruction-memory word-address width.
REQ-002 SHALL have parameter BOOT_LOAD, default 1; 1 = enter LOAD after reset, 0 = enter RUN.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port fetch_req  in  1  fetch stage requests an instruction read.
REQ-006 SHALL have port fetch_addr  in  32  byte address of the read.
REQ-007 SHALL have port fetch_gnt  out  1  read accepted this cycle.
REQ-008 SHALL have port fetch_valid  out  1  fetch_data valid (one-cycle pulse).
REQ-009 SHALL have port fetch_data  out  32  instruction word.
REQ-010 SHALL have port fetch_stall  out  1  request not accepted; fetch holds its PC.
REQ-011 SHALL have ports ld_req in 1, ld_addr in 32, ld_wdata in 32: loader (SPART) write request, byte address, data.
REQ-012 SHALL have ports ld_gnt out 1 (write accepted) and ld_done in 1 (single-cycle end-of-image pulse).
REQ-013 SHALL have port cpu_halted  in  1  the fetch stage's HALTED indication.
REQ-014 SHALL have port cpu_rst  out  1  holds the CPU in reset while loading.
REQ-015 SHALL have ports mem_en, mem_we (out 1 each), mem_addr (out ADDR_W), mem_wdata (out 32), mem_rdata (in 32): single-port synchronous RAM, one-cycle read latency.
REQ-016 SHALL have ports ld_count out 16 (words written since entering LOAD) and misalign out 1 (sticky error flag).

Function
REQ-017 SHALL implement FSM states LOAD, DRAIN, RUN, with LOAD, DRAIN, RUN encoded in 2 bits.
REQ-018 In LOAD: cpu_rst=1; fetch_gnt=0; ld_gnt=ld_req; on ld_req, mem_en=1, mem_we=1, mem_addr=ld_addr[ADDR_W+1:2], mem_wdata=ld_wdata.
REQ-019 LOAD -> DRAIN on ld_done; a write presented in the ld_done cycle SHALL still be performed and counted.
REQ-020 DRAIN SHALL last exactly one cycle with cpu_rst=1 and no memory access, then -> RUN.
REQ-021 In RUN: cpu_rst=0; fetch has priority; fetch_gnt=fetch_req; ld_gnt=0 while cpu_halted=0.
REQ-022 RUN -> LOAD when ld_req=1 and cpu_halted=1 and fetch_req=0 in the same cycle; the write is not granted until the first LOAD cycle.
REQ-023 Fetch read latency SHALL be 1: grant in cycle n -> fetch_valid=1 and fetch_data=mem_rdata in n+1.
REQ-024 fetch_stall SHALL equal fetch_req & ~fetch_gnt, combinational.
REQ-025 Out-of-range read (fetch_addr[31:ADDR_W+2] nonzero): no memory access, fetch_valid=1 next cycle, fetch_data=32'h0000_0000 (HALT opcode).
REQ-026 Out-of-range loader write SHALL be granted and dropped: mem_en=0, ld_count not incremented.
REQ-027 Address bits [1:0] nonzero on a granted access SHALL set misalign; the access proceeds with bits dropped.
REQ-028 ld_count SHALL clear on entry to LOAD, increment by 1 per performed write, and saturate at 16'hFFFF.
REQ-029 A fetch_valid pending at RUN -> LOAD SHALL still be delivered the following cycle.
REQ-030 mem_en=0 and mem_we=0 in every cycle with no granted access.

Reset
REQ-031 On rst: state = LOAD if BOOT_LOAD else RUN; ld_count=0; misalign=0; fetch_valid=0; fetch_data=0.
REQ-032 In the rst cycle, mem_en=0, mem_we=0, fetch_gnt=0, ld_gnt=0, and cpu_rst=1.
REQ-033 rst asserted mid-LOAD or mid-read SHALL abandon the access; no partial write or stale fetch_valid after release.

Structure
REQ-034 State encoding, the HALT opcode constant (32'h0) and the ADDR_W default SHALL live in a shared package, imem_pkg.
REQ-035 The design SHALL be one FSM module; the ld_count saturating counter MAY be a sub-module, sat_cnt16.

Verification
REQ-036 BOOT_LOAD=1, rst, 4 writes to 0x0,0x4,0x8,0xC (ld_done with the 4th) -> ld_count=4, DRAIN 1 cycle, RUN, cpu_rst falls.
REQ-037 RUN, fetch_req at 0x8 in cycle n -> fetch_valid in n+1 with the word written at 0x8.
REQ-038 RUN, cpu_halted=0, ld_req=1 for 10 cycles -> ld_gnt=0 throughout, no write, fetch unaffected.
REQ-039 cpu_halted=1, fetch_req=0, ld_req=1 -> LOAD next cycle, cpu_rst=1, ld_count=0, then the write is granted.
REQ-040 fetch_addr=0x0010_0000 (out of range) -> no mem_en, fetch_data=0 next cycle; fetch_addr=0x6 -> misalign=1, word 1 returned.
REQ-041 rst pulse in the middle of a LOAD burst -> no memory write in the rst cycle, ld_count=0, state per BOOT_LOAD.
